wb_stage_buf: RTL and testbench

WB_STAGE_BUF -- requirements
Module: wb_stage_buf

---
 rtl/wb_stage_buf_pkg.sv | 23 ++
 rtl/wb_stage_mem.sv | 32 +++
 rtl/wb_stage_buf.sv | 113 +++++++++++
 tb/tb_wb_stage_buf.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_buf_pkg.sv
// wb_stage_buf_pkg -- shared pipeline definitions for the write-back stage.
//   WB_DATA_W / WB_HAZ_W / WB_DEPTH : default widths and buffer depth
//   WB_HAZ_*                        : hazard tag encodings
//   wb_entry_t                      : one buffered {hazard, data} entry at
//                                     the default widths
package wb_stage_buf_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_HAZ_W  = 2;
  localparam int WB_DEPTH  = 2;

  // Hazard tag encodings carried alongside each write-back word.
  localparam logic [WB_HAZ_W-1:0] WB_HAZ_NONE  = 2'b00;  // no dependency
  localparam logic [WB_HAZ_W-1:0] WB_HAZ_RAW   = 2'b01;  // read-after-write
  localparam logic [WB_HAZ_W-1:0] WB_HAZ_LOAD  = 2'b10;  // load-use
  localparam logic [WB_HAZ_W-1:0] WB_HAZ_MULTI = 2'b11;  // multi-cycle producer

  typedef struct packed {
    logic [WB_HAZ_W-1:0]  hazard;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_mem.sv
// wb_stage_mem -- entry storage for wb_stage_buf.
//   Ports: clk (write clock), we/waddr/wdata (synchronous write port),
//          raddr/rdata (asynchronous read port).
//   DEPTH x WIDTH words, no reset: contents are only meaningful where the
//   owning buffer's pointers say so.
module wb_stage_mem
  import wb_stage_buf_pkg::*;
#(
  parameter int WIDTH = WB_HAZ_W + WB_DATA_W,
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read so the head entry is visible in the same cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/wb_stage_buf.sv
// wb_stage_buf -- write-back stage FIFO buffer of {hazard, data} entries.
//   Ports: clk, rst (async, active-high), stall (freeze), flush (discard),
//          in_valid/in_ready/in_hazard/in_data (upstream handshake),
//          out_valid/out_ready/out_hazard/out_data (downstream handshake),
//          count (occupancy, $clog2(DEPTH)+1 bits).
//   Optional: define WB_STAGE_BUF_STALLCNT_EN to add output stall_cnt, a
//   16-bit saturating count of edges spent stalled with data buffered.
module wb_stage_buf
  import wb_stage_buf_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int HAZ_W  = WB_HAZ_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [HAZ_W-1:0]         in_hazard,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [HAZ_W-1:0]         out_hazard,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count
`ifdef WB_STAGE_BUF_STALLCNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = HAZ_W + DATA_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign empty     = (count_reg == '0);
  // Readiness depends only on the registered count: a pop at full frees
  // space for the following cycle, never the same one.
  assign in_ready  = !stall && !flush && (count_reg != FULL);
  assign out_valid = !empty && !stall;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  // push/pop are already gated by stall, so stall needs no branch here;
  // flush overrides everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  wb_stage_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata ({in_hazard, in_data}),
    .raddr (rd_ptr_reg),
    .rdata (head)
  );

  // Stale storage must never leak out while the buffer is empty.
  assign {out_hazard, out_data} = empty ? '0 : head;
  assign count = count_reg;

`ifdef WB_STAGE_BUF_STALLCNT_EN
  logic [15:0] stall_cnt_reg;

  // Deliberately untouched by flush: it measures stall pressure over time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (stall && !empty && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
module tb_wb_stage_buf;
  import wb_stage_buf_pkg::*;

  localparam int DATA_W = WB_DATA_W;
  localparam int HAZ_W  = WB_HAZ_W;
  localparam int DEPTH  = WB_DEPTH;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [HAZ_W-1:0]  in_hazard;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [HAZ_W-1:0]  out_hazard;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0]     count;
`ifdef WB_STAGE_BUF_STALLCNT_EN
  logic [15:0]       stall_cnt;
`endif

  wb_stage_buf #(
    .DATA_W (DATA_W),
    .HAZ_W  (HAZ_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_hazard  (in_hazard),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hazard (out_hazard),
    .out_data   (out_data),
    .count      (count)
`ifdef WB_STAGE_BUF_STALLCNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain queue of entries plus a stall-edge tally.
  wb_entry_t model_q[$];
  int        exp_stall_cnt = 0;
  bit        last_push;
  int        err_cnt = 0;
  int        chk_cnt = 0;
  int        cyc = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare outputs mid-cycle against the model, then advance the model
  // and the DUT by one rising edge. Returns at posedge + 1.
  task automatic cycle();
    bit        exp_ready;
    bit        exp_valid;
    bit        push;
    bit        pop;
    wb_entry_t head;
    @(negedge clk);
    exp_ready = !stall && !flush && (model_q.size() < DEPTH);
    exp_valid = (model_q.size() != 0) && !stall;
    head      = (model_q.size() != 0) ? model_q[0] : '0;
    check_val("in_ready",   64'(in_ready),   64'(exp_ready));
    check_val("out_valid",  64'(out_valid),  64'(exp_valid));
    check_val("out_hazard", 64'(out_hazard), 64'(head.hazard));
    check_val("out_data",   64'(out_data),   64'(head.data));
    check_val("count",      64'(count),      64'(model_q.size()));
`ifdef WB_STAGE_BUF_STALLCNT_EN
    check_val("stall_cnt",  64'(stall_cnt),  64'(exp_stall_cnt));
`endif
    push = in_valid && exp_ready;
    pop  = exp_valid && out_ready && !flush;
    if (stall && (model_q.size() != 0) && (exp_stall_cnt < 65535)) exp_stall_cnt++;
    if (flush) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (push) model_q.push_back({in_hazard, in_data});
    end
    last_push = push;
    if (push || pop || flush)
      $display("cyc %0d push=%0b pop=%0b flush=%0b stall=%0b data_in=%h data_out=%h occ=%0d",
               cyc, push, pop, flush, stall, in_data, head.data, model_q.size());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seq;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_hazard = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_count",     64'(count),     64'(0));
    check_val("rst_out_data",  64'(out_data),  64'(0));
    rst = 1'b0;

    // First edge after reset accepts a push; visible one cycle later.
    in_valid = 1'b1; in_hazard = 2'b01; in_data = 32'hDEAD_BEEF;
    cycle();
    in_valid = 1'b0;
    check_val("first_valid",  64'(out_valid),  64'(1));
    check_val("first_data",   64'(out_data),   64'(32'hDEAD_BEEF));
    check_val("first_hazard", 64'(out_hazard), 64'(2'b01));
    check_val("first_count",  64'(count),      64'(1));
    cycle();

    // Clear, then three back-to-back pushes into a depth-2 buffer.
    flush = 1'b1; cycle(); flush = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hA000_0000 + i; in_hazard = HAZ_W'(i);
      cycle();
    end
    in_valid = 1'b0;
    check_val("full_count", 64'(count),    64'(2));
    check_val("full_ready", 64'(in_ready), 64'(0));

    // Streaming from full: order must survive pointer wrap across 10 words.
    in_valid = 1'b1; out_ready = 1'b1; seq = 0;
    for (int i = 0; i < 40 && seq < 10; i++) begin
      in_data = 32'h1000 + seq; in_hazard = HAZ_W'(seq);
      cycle();
      if (last_push) seq++;
    end
    check_val("stream_words", 64'(seq), 64'(10));
    in_valid = 1'b0;
    repeat (4) cycle();

    // Stall with two entries held.
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (2) begin
      in_data = $urandom; in_hazard = HAZ_W'($urandom);
      cycle();
    end
    stall = 1'b1; out_ready = 1'b1;
    repeat (3) cycle();
    check_val("stall_count", 64'(count),     64'(2));
    check_val("stall_valid", 64'(out_valid), 64'(0));
`ifdef WB_STAGE_BUF_STALLCNT_EN
    check_val("stall_cnt_3", 64'(stall_cnt), 64'(3));
`endif

    // Flush beats stall and push.
    flush = 1'b1; in_data = 32'hBAD0_BAD0;
    cycle();
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    check_val("flush_count", 64'(count),     64'(0));
    check_val("flush_data",  64'(out_data),  64'(0));
    check_val("flush_valid", 64'(out_valid), 64'(0));
    cycle();

    // Asynchronous reset mid-cycle with one entry held.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5555_AAAA;
    cycle();
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("arst_valid", 64'(out_valid), 64'(0));
    check_val("arst_count", 64'(count),     64'(0));
    check_val("arst_data",  64'(out_data),  64'(0));
    model_q.delete();
    exp_stall_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'h0BAD_F00D;
    cycle();
    in_valid = 1'b0;
    check_val("post_rst_count", 64'(count), 64'(1));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      in_hazard = HAZ_W'($urandom);
      in_data   = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
